mesi_isc_fifo_reader: RTL and testbench

MESI_ISC_FIFO_READER -- requirements
Module: mesi_isc_fifo_reader

---
 rtl/mesi_isc_fifo_reader.sv | 139 +++++++++++++
 tb/tb_mesi_isc_fifo_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mesi_isc_fifo_reader.sv
// Two-entry skid reader between a show-ahead FIFO and a ready/valid consumer.
// Optional debug counters are compiled in with MESI_ISC_FIFO_READER_STATS_EN.
module mesi_isc_fifo_reader #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_o,
    input  logic                  enable_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i,
    output logic [15:0]           dbg_rd_cnt_o,
    output logic [7:0]            dbg_drop_cnt_o
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  rd_s;
    logic                  pop_s;

    // Read never looks at out_ready_i: the second slot absorbs the pop latency.
    assign rd_s        = enable_i & ~fifo_empty_i & ~flush_i & (state_q != S2);
    assign fifo_rd_o   = rd_s;
    assign out_valid_o = (state_q != S0);
    assign out_data_o  = buf0_q;
    assign pop_s       = out_valid_o & out_ready_i;

    // State and entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
            buf0_q  <= '0;
            buf1_q  <= '0;
        end else begin
            state_q <= state_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
        end
    end

    // Next-state and buffer update.
    always_comb begin
        state_d = state_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        if (flush_i) begin
            state_d = S0;
            buf0_d  = '0;
            buf1_d  = '0;
        end else begin
            case (state_q)
                S0: begin
                    if (rd_s) begin
                        state_d = S1;
                        buf0_d  = fifo_data_i;
                    end else begin
                        state_d = S0;
                    end
                end
                S1: begin
                    if (rd_s && pop_s) begin
                        buf0_d = fifo_data_i;
                    end else if (rd_s) begin
                        state_d = S2;
                        buf1_d  = fifo_data_i;
                    end else if (pop_s) begin
                        state_d = S0;
                    end else begin
                        state_d = S1;
                    end
                end
                S2: begin
                    if (pop_s) begin
                        state_d = S1;
                        buf0_d  = buf1_q;
                    end else begin
                        state_d = S2;
                    end
                end
                default: begin
                    state_d = S0;
                end
            endcase
        end
    end

`ifdef MESI_ISC_FIFO_READER_STATS_EN
    logic [15:0] dbg_rd_cnt_q, dbg_rd_cnt_d;
    logic [7:0]  dbg_drop_cnt_q, dbg_drop_cnt_d;
    logic [1:0]  drop_n_s;
    logic [8:0]  drop_sum_s;

    // Entries lost to a flush: occupancy minus the one delivered that cycle.
    always_comb begin
        drop_n_s = 2'd0;
        if (flush_i) begin
            case (state_q)
                S1:      drop_n_s = pop_s ? 2'd0 : 2'd1;
                S2:      drop_n_s = pop_s ? 2'd1 : 2'd2;
                default: drop_n_s = 2'd0;
            endcase
        end else begin
            drop_n_s = 2'd0;
        end
        drop_sum_s     = {1'b0, dbg_drop_cnt_q} + {7'd0, drop_n_s};
        dbg_drop_cnt_d = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
        dbg_rd_cnt_d   = rd_s ? (dbg_rd_cnt_q + 16'd1) : dbg_rd_cnt_q;
    end

    // Debug counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_rd_cnt_q   <= 16'd0;
            dbg_drop_cnt_q <= 8'd0;
        end else begin
            dbg_rd_cnt_q   <= dbg_rd_cnt_d;
            dbg_drop_cnt_q <= dbg_drop_cnt_d;
        end
    end

    assign dbg_rd_cnt_o   = dbg_rd_cnt_q;
    assign dbg_drop_cnt_o = dbg_drop_cnt_q;
`else
    assign dbg_rd_cnt_o   = 16'd0;
    assign dbg_drop_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_mesi_isc_fifo_reader.sv
// Directed bench for mesi_isc_fifo_reader with a small show-ahead FIFO model.
module tb_mesi_isc_fifo_reader;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_empty_i;
    logic          fifo_rd_o;
    logic          enable_i;
    logic          flush_i;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_ready_i;
    logic [15:0]   dbg_rd_cnt_o;
    logic [7:0]    dbg_drop_cnt_o;

    logic [DW-1:0] mem [0:63];
    logic [5:0]    head = 6'd0;
    logic [5:0]    tail = 6'd0;
    int            rd_seen = 0;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    mesi_isc_fifo_reader #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_data_i    (fifo_data_i),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_rd_o      (fifo_rd_o),
        .enable_i       (enable_i),
        .flush_i        (flush_i),
        .out_valid_o    (out_valid_o),
        .out_data_o     (out_data_o),
        .out_ready_i    (out_ready_i),
        .dbg_rd_cnt_o   (dbg_rd_cnt_o),
        .dbg_drop_cnt_o (dbg_drop_cnt_o)
    );

    assign fifo_empty_i = (head == tail);
    assign fifo_data_i  = mem[head];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO model pops its head on each read strobe; underflow is flagged here.
    always @(posedge clk) begin
        if (fifo_rd_o) begin
            check_eq("no_underflow", {31'd0, fifo_empty_i}, 32'd0);
            head    <= head + 6'd1;
            rd_seen <= rd_seen + 1;
        end
    end

    task automatic push(input logic [DW-1:0] d);
        mem[tail] = d;
        tail      = tail + 6'd1;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d);
        check_eq({tag, "_valid"}, {31'd0, out_valid_o}, {31'd0, v});
        if (v) check_eq({tag, "_data"}, out_data_o, d);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        rst = 1'b1; enable_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
        #12;
        check_eq("rst_valid", {31'd0, out_valid_o}, 32'd0);
        check_eq("rst_data", out_data_o, 32'd0);
        check_eq("rst_rd", {31'd0, fifo_rd_o}, 32'd0);
        check_eq("rst_rdcnt", {16'd0, dbg_rd_cnt_o}, 32'd0);
        check_eq("rst_dropcnt", {24'd0, dbg_drop_cnt_o}, 32'd0);
        cyc(); rst = 1'b0;

        // Single entry
        push(32'hA5); #1;
        check_eq("single_rd", {31'd0, fifo_rd_o}, 32'd1);
        cyc(); chk_out("single_1", 1'b1, 32'hA5);
        check_eq("single_rd_after", {31'd0, fifo_rd_o}, 32'd0);
        cyc(); chk_out("single_2", 1'b0, 32'h0);
        check_eq("single_rdseen", rd_seen, 32'd1);

        // Stream at full rate
        for (int i = 1; i <= 4; i++) push(i);
        #1 check_eq("stream_rd0", {31'd0, fifo_rd_o}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc(); chk_out("stream", 1'b1, i);
        end
        cyc(); chk_out("stream_end", 1'b0, 32'h0);
        check_eq("stream_rdseen", rd_seen, 32'd5);
`ifdef MESI_ISC_FIFO_READER_STATS_EN
        check_eq("stream_rdcnt", {16'd0, dbg_rd_cnt_o}, 32'd5);
`else
        check_eq("stream_rdcnt", {16'd0, dbg_rd_cnt_o}, 32'd0);
`endif

        // Backpressure fills both slots
        out_ready_i = 1'b0;
        push(32'h10); push(32'h11); push(32'h12);
        cyc(); cyc(); chk_out("bp_full", 1'b1, 32'h10);
        check_eq("bp_rd_blocked", {31'd0, fifo_rd_o}, 32'd0);
        cyc(); chk_out("bp_hold", 1'b1, 32'h10);
        check_eq("bp_rdseen", rd_seen, 32'd7);
        out_ready_i = 1'b1;
        cyc(); chk_out("bp_d1", 1'b1, 32'h11);
        cyc(); chk_out("bp_d2", 1'b1, 32'h12);
        cyc(); chk_out("bp_end", 1'b0, 32'h0);
        check_eq("bp_rdseen2", rd_seen, 32'd8);

        // Flush while holding two entries
        out_ready_i = 1'b0;
        push(32'h20); push(32'h21); push(32'h22);
        cyc(); cyc(); chk_out("fl_full", 1'b1, 32'h20);
        flush_i = 1'b1; #1;
        check_eq("fl_no_rd", {31'd0, fifo_rd_o}, 32'd0);
        cyc(); flush_i = 1'b0;
        chk_out("fl_s0", 1'b0, 32'h0);
`ifdef MESI_ISC_FIFO_READER_STATS_EN
        check_eq("fl_dropcnt", {24'd0, dbg_drop_cnt_o}, 32'd2);
`else
        check_eq("fl_dropcnt", {24'd0, dbg_drop_cnt_o}, 32'd0);
`endif
        #1 check_eq("fl_resume_rd", {31'd0, fifo_rd_o}, 32'd1);
        out_ready_i = 1'b1;
        cyc(); chk_out("fl_after", 1'b1, 32'h22);
        cyc(); chk_out("fl_end", 1'b0, 32'h0);

        // Enable low: no reads, held entries drain
        out_ready_i = 1'b0;
        push(32'h30); push(32'h31); push(32'h32);
        cyc(); cyc(); chk_out("en_full", 1'b1, 32'h30);
        enable_i = 1'b0; out_ready_i = 1'b1; #1;
        check_eq("en_rd0", {31'd0, fifo_rd_o}, 32'd0);
        cyc(); chk_out("en_d1", 1'b1, 32'h31);
        check_eq("en_rd1", {31'd0, fifo_rd_o}, 32'd0);
        cyc(); chk_out("en_drained", 1'b0, 32'h0);
        check_eq("en_rd2", {31'd0, fifo_rd_o}, 32'd0);
        enable_i = 1'b1;
        cyc(); chk_out("en_resume", 1'b1, 32'h32);
        cyc(); chk_out("en_end", 1'b0, 32'h0);
        check_eq("en_rdseen", rd_seen, 32'd14);

        // Asynchronous reset in S1
        out_ready_i = 1'b0;
        push(32'h40);
        cyc(); chk_out("rs_s1", 1'b1, 32'h40);
`ifdef MESI_ISC_FIFO_READER_STATS_EN
        check_eq("rs_rdcnt_pre", {16'd0, dbg_rd_cnt_o}, 32'd15);
`endif
        #2 rst = 1'b1;
        #1;
        check_eq("rs_valid", {31'd0, out_valid_o}, 32'd0);
        check_eq("rs_data", out_data_o, 32'd0);
        check_eq("rs_rdcnt", {16'd0, dbg_rd_cnt_o}, 32'd0);
        check_eq("rs_dropcnt", {24'd0, dbg_drop_cnt_o}, 32'd0);
        cyc(); rst = 1'b0;
        cyc(); chk_out("rs_after", 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
